i_skew_feeder: RTL and testbench
================================

Name: i_skew_feeder

Overview:
- Input-side feeder for the systolic array: the counterpart of the output row/column collection path.
- Accepts a serial byte stream with a valid/ready handshake and demultiplexes it into per-row tile buffers.
- Once a full ROW×K_LEN tile is loaded, drains it into the array's west edge with diagonal skew: row r starts r cycles after row 0.
- Output lanes use the array's packed 9-bit format, {valid, data[7:0]} per row.

Parameters:
- ROW, 9, number of array rows (one output lane per row).
- W_DATA, 8, data width per element.
- K_LEN, 16, elements per row per tile; minimum 1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: synchronous, active-high.
- i_data  in  W_DATA  serial input element.
- i_data_valid  in  1  i_data is valid.
- o_data_ready  out  1  feeder accepts a beat this cycle.
- i_array_ready  in  1  array advances this cycle; low stalls the drain.
- o_data  out  ROW*9  lane r: bit r*9+8 is valid, bits r*9+7:r*9 are data.
- o_tile_done  out  1  one-cycle pulse coincident with the final drained element.
- o_busy  out  1  high while in DRAIN.

Behaviour:
- Reset values: state LOAD, all counters 0, o_data all zero, o_tile_done 0, o_busy 0, o_data_ready 1. The buffer contents are don't-care.
- LOAD state:
  - A beat is accepted when i_data_valid & o_data_ready.
  - Stream order is column-major: beat n writes row (n mod ROW), element (n div ROW). Track this with a row counter that wraps at ROW-1 and increments the element counter.
  - Beats with i_data_valid low are ignored.
  - o_data_ready is high throughout LOAD.
- LOAD -> DRAIN: on acceptance of beat ROW*K_LEN-1. o_data_ready is low starting the next cycle, and i_data_valid is ignored while low.
- DRAIN state:
  - Step counter t runs 0..K_LEN+ROW-2.
  - In each DRAIN cycle with i_array_ready=1, step t is issued and t increments.
  - For step t, lane r is valid iff 0 <= t-r < K_LEN, with data = buf[r][t-r]; otherwise the lane is 9'b0.
  - o_data is registered: step t appears the cycle after it is issued.
- Stall: a DRAIN cycle with i_array_ready=0 issues nothing. t holds, and the next-cycle o_data is all zero, so no valid bits are set.
- DRAIN -> LOAD: after issuing step K_LEN+ROW-2.
  - o_tile_done goes high in the next cycle, alongside lane ROW-1 carrying element K_LEN-1.
  - The state is LOAD in that same cycle, so o_data_ready=1 and a new tile may start loading immediately.
- o_busy = (state == DRAIN).
- Latency: last load beat at cycle N -> DRAIN at N+1 -> first output (lane 0, element 0) at N+2 if i_array_ready=1 at N+1. An unstalled drain is K_LEN+ROW-1 output cycles.
- Reset mid-LOAD or mid-DRAIN:
  - The partial tile is discarded.
  - o_data is zeroed the next cycle, and o_tile_done is not pulsed.
  - The state returns to LOAD with counters cleared.
- Simultaneous i_rst and input beat: reset wins and the beat is dropped.
- K_LEN=1: the drain is ROW cycles with exactly one valid lane per cycle.
- Counter widths: $clog2 of (ROW), (K_LEN), and (K_LEN+ROW-1), each at least 1 bit.

Decomposition:
- Package i_feed_pkg holds:
  - localparam LANE_W=9;
  - the state enum {S_LOAD, S_DRAIN};
  - a function computing DRAIN_LEN = K_LEN+ROW-1.
- Sub-module i_row_buffer (one instance per row, generated):
  - K_LEN×W_DATA storage;
  - write port (we, waddr, wdata);
  - combinational read by index.
- The top level owns the FSM, counters, skew index arithmetic and the output register.

Test Plan (ROW=3, K_LEN=4 unless stated):
- Basic tile: stream 0x00..0x0B with no gaps. Element k of row r = 3k+r. Drain cycles d0..d5 carry:
  - d0: lane0=0x00;
  - d1: lane0=0x03, lane1=0x01;
  - d2: lane0=0x06, lane1=0x04, lane2=0x02;
  - d3: lane0=0x09, lane1=0x07, lane2=0x05;
  - d4: lane1=0x0A, lane2=0x08;
  - d5: lane2=0x0B with o_tile_done=1.
  - All other lanes are 9'b0.
- Input gaps and backpressure:
  - Toggle i_data_valid 1,0,1,0 during load; the drain output must match the basic tile.
  - Drive i_data_valid=1 with 0xFF during DRAIN; 0xFF never appears and o_data_ready stays 0.
- Stall: i_array_ready=0 for 2 cycles after step d1 is issued. Output shows two all-zero cycles, then resumes at d2 values. o_tile_done arrives 2 cycles later than unstalled.
- Back-to-back tiles: begin the second tile (0x20..0x2B) in the o_tile_done cycle. The second drain starts exactly ROW*K_LEN+1 cycles after the first o_tile_done, assuming no input gaps.
- Reset mid-drain: assert i_rst at d2. The next cycle has o_data=0 and o_tile_done=0; the next cycle after that has o_data_ready=1. A fresh tile drains correctly.
- Degenerate case (ROW=9, K_LEN=1): stream 0x10..0x18. Over 9 drain cycles, exactly lane r is valid with 0x10+r at cycle r, and o_tile_done is asserted at cycle 8.

Source files
------------

// File: rtl/i_feed_pkg.sv
// i_feed_pkg: shared lane format, feeder states and drain-length helper.
package i_feed_pkg;
    localparam int LANE_W = 9;
    typedef enum logic {S_LOAD, S_DRAIN} state_t;
    function automatic int drain_len(input int k_len, input int row);
        return k_len + row - 1;
    endfunction
endpackage

// File: rtl/i_skew_feeder_row_buffer.sv
// i_row_buffer: one row's K_LEN-deep tile storage, synchronous write, combinational read.
module i_row_buffer #(
    parameter int K_LEN  = 16,
    parameter int W_DATA = 8,
    parameter int AW     = 4
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [W_DATA-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [W_DATA-1:0] o_rdata
);
    logic [W_DATA-1:0] r_mem [K_LEN];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/i_skew_feeder.sv
// i_skew_feeder: loads a column-major ROW x K_LEN tile from a serial stream,
// then drains it into the array west edge with row r delayed r steps.
module i_skew_feeder
    import i_feed_pkg::*;
#(
    parameter int ROW    = 9,
    parameter int W_DATA = 8,
    parameter int K_LEN  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [W_DATA-1:0]     i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    input  logic                  i_array_ready,
    output logic [ROW*LANE_W-1:0] o_data,
    output logic                  o_tile_done,
    output logic                  o_busy
);
    localparam int DRAIN_LEN = drain_len(K_LEN, ROW);
    localparam int RW = ROW > 1 ? $clog2(ROW) : 1;
    localparam int KW = K_LEN > 1 ? $clog2(K_LEN) : 1;
    localparam int TW = DRAIN_LEN > 1 ? $clog2(DRAIN_LEN) : 1;

    state_t                r_state, w_state_nxt;
    logic [RW-1:0]         r_row;
    logic [KW-1:0]         r_elem;
    logic [TW-1:0]         r_t;
    logic [ROW*LANE_W-1:0] r_data, w_data_nxt;
    logic                  r_tile_done;
    logic                  w_accept, w_last_beat, w_issue, w_last_step;

    assign w_accept    = (r_state == S_LOAD) && i_data_valid;
    assign w_last_beat = w_accept && r_row == RW'(ROW-1) && r_elem == KW'(K_LEN-1);
    assign w_issue     = (r_state == S_DRAIN) && i_array_ready;
    assign w_last_step = w_issue && r_t == TW'(DRAIN_LEN-1);

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = r_state == S_LOAD ? (w_last_beat ? S_DRAIN : S_LOAD)
                                        : (w_last_step ? S_LOAD : S_DRAIN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_LOAD;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row       <= '0;
            r_elem      <= '0;
            r_t         <= '0;
            r_data      <= '0;
            r_tile_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_row <= r_row == RW'(ROW-1) ? '0 : r_row + 1'b1;
                if (r_row == RW'(ROW-1)) r_elem <= r_elem == KW'(K_LEN-1) ? '0 : r_elem + 1'b1;
            end
            if (w_issue) r_t <= w_last_step ? '0 : r_t + 1'b1;
            r_data      <= w_data_nxt;
            r_tile_done <= w_last_step;
        end
    end

    // Row g carries element t-g, valid only while that index lies inside the tile.
    for (genvar g = 0; g < ROW; g++) begin : g_row
        logic [TW:0]       w_diff;
        logic              w_live;
        logic [W_DATA-1:0] w_rdata;
        assign w_diff = {1'b0, r_t} - (TW+1)'(g);
        assign w_live = w_issue && r_t >= TW'(g) && w_diff < (TW+1)'(K_LEN);
        i_row_buffer #(.K_LEN(K_LEN), .W_DATA(W_DATA), .AW(KW)) u_buf (
            .i_clk  (i_clk),
            .i_we   (w_accept && r_row == RW'(g)),
            .i_waddr(r_elem),
            .i_wdata(i_data),
            .i_raddr(w_live ? KW'(w_diff) : '0),
            .o_rdata(w_rdata)
        );
        assign w_data_nxt[g*LANE_W +: LANE_W] = w_live ? {1'b1, w_rdata} : '0;
    end

    assign o_data       = r_data;
    assign o_tile_done  = r_tile_done;
    assign o_data_ready = r_state == S_LOAD;
    assign o_busy       = r_state == S_DRAIN;
endmodule

// File: tb/tb_i_skew_feeder.sv
// tb_i_skew_feeder: tile-level reference model plus directed and random stimulus
// for a 3x4 feeder, and literal checks for a 9x1 degenerate feeder.
module tb_i_skew_feeder;
    localparam int R = 3;
    localparam int K = 4;

    logic        clk, rst;
    logic [7:0]  data, k_data;
    logic        valid, ready, aready, done, busy;
    logic [26:0] odata;
    logic        k_valid, k_ready, k_aready, k_done, k_busy;
    logic [80:0] k_odata;
    int          n_tests = 0;
    int          n_fail = 0;

    i_skew_feeder #(.ROW(R), .W_DATA(8), .K_LEN(K)) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_data_valid(valid),
        .o_data_ready(ready), .i_array_ready(aready), .o_data(odata),
        .o_tile_done(done), .o_busy(busy)
    );

    i_skew_feeder #(.ROW(9), .W_DATA(8), .K_LEN(1)) dut_k1 (
        .i_clk(clk), .i_rst(rst), .i_data(k_data), .i_data_valid(k_valid),
        .o_data_ready(k_ready), .i_array_ready(k_aready), .o_data(k_odata),
        .o_tile_done(k_done), .o_busy(k_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: whole-tile view, beat n lands at row n%R, element n/R;
    // drain step t shows element t-r on row r.
    logic [7:0]  m_buf [R][K];
    logic [26:0] m_data = '0;
    bit          m_busy = 0, m_done = 0, m_live = 0;
    int          m_n = 0, m_t = 0;

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_data", odata, m_data);
            chk("model_done", done, m_done);
            chk("model_ready", ready, !m_busy);
            chk("model_busy", busy, m_busy);
        end
        m_data = '0;
        m_done = 0;
        if (rst) begin
            m_live = 1;
            m_busy = 0;
            m_n = 0;
            m_t = 0;
        end else if (!m_busy) begin
            if (valid) begin
                m_buf[m_n % R][m_n / R] = data;
                m_n++;
                if (m_n == R*K) begin
                    m_busy = 1;
                    m_n = 0;
                    m_t = 0;
                end
            end
        end else if (aready) begin
            for (int r = 0; r < R; r++)
                if (m_t - r >= 0 && m_t - r < K) m_data[r*9 +: 9] = {1'b1, m_buf[r][m_t-r]};
            if (m_t == K + R - 2) begin
                m_done = 1;
                m_busy = 0;
            end else m_t++;
        end
    end

    logic [26:0] tbl [6];

    function automatic logic [26:0] rebase(input logic [26:0] x, input logic [7:0] b);
        for (int r = 0; r < R; r++)
            if (x[r*9+8]) x[r*9 +: 8] = x[r*9 +: 8] + b;
        return x;
    endfunction

    task automatic stream(input logic [7:0] base, input bit gaps);
        for (int i = 0; i < R*K; i++) begin
            valid = 1'b1;
            data  = base + 8'(i);
            tick();
            if (gaps && i < R*K-1) begin
                valid = 1'b0;
                data  = 8'hEE;
                tick();
            end
        end
        valid = 1'b0;
    endtask

    task automatic run_drain(input logic [7:0] base, input bit stall, input bit junk);
        int seq[$];
        if (stall) seq = '{0, 1, -1, -1, 2, 3, 4, 5};
        else       seq = '{0, 1, 2, 3, 4, 5};
        for (int i = 0; i < seq.size(); i++) begin
            tick();
            chk("drain_data", odata, seq[i] < 0 ? 27'd0 : rebase(tbl[seq[i]], base));
            chk("drain_done", done, seq[i] == 5);
            if (junk && seq[i] != 5) chk("junk_ready", ready, 1'b0);
            if (stall) aready = !(i == 1 || i == 2);
            if (junk && i == seq.size() - 2) valid = 1'b0;
        end
    endtask

    initial begin
        tbl[0] = {9'h000, 9'h000, 9'h100};
        tbl[1] = {9'h000, 9'h101, 9'h103};
        tbl[2] = {9'h102, 9'h104, 9'h106};
        tbl[3] = {9'h105, 9'h107, 9'h109};
        tbl[4] = {9'h108, 9'h10A, 9'h000};
        tbl[5] = {9'h10B, 9'h000, 9'h000};
        rst = 1'b1; valid = 1'b0; data = '0; aready = 1'b1;
        k_valid = 1'b0; k_data = '0; k_aready = 1'b1;
        tick();
        tick();
        chk("rst_data", odata, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_k1_data", k_odata, 0);
        chk("rst_k1_ready", k_ready, 1);
        rst = 1'b0;

        stream(8'h00, 0);
        chk("load_to_drain_busy", busy, 1);
        chk("load_to_drain_ready", ready, 0);
        run_drain(8'h00, 0, 0);

        stream(8'h00, 1);
        valid = 1'b1;
        data  = 8'hFF;
        run_drain(8'h00, 0, 1);

        stream(8'h00, 0);
        run_drain(8'h00, 1, 0);

        stream(8'h00, 0);
        run_drain(8'h00, 0, 0);
        stream(8'h20, 0);
        chk("b2b_gap_data", odata, 0);
        chk("b2b_gap_busy", busy, 1);
        run_drain(8'h20, 0, 0);

        stream(8'h00, 0);
        tick();
        tick();
        tick();
        chk("pre_rst_d2", odata, tbl[2]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_data", odata, 0);
        chk("mid_rst_done", done, 0);
        tick();
        chk("mid_rst_ready", ready, 1);
        stream(8'h40, 0);
        run_drain(8'h40, 0, 0);

        repeat (3000) begin
            rst    = ($urandom % 400) == 0;
            valid  = ($urandom % 4) != 0;
            data   = 8'($urandom);
            aready = ($urandom % 4) != 0;
            tick();
        end
        rst = 1'b0; valid = 1'b0; aready = 1'b1;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            k_valid = 1'b1;
            k_data  = 8'h10 + 8'(i);
            tick();
        end
        k_valid = 1'b0;
        chk("k1_busy", k_busy, 1);
        for (int c = 0; c < 9; c++) begin
            tick();
            chk("k1_data", k_odata, 81'(9'h110 + c) << (9*c));
            chk("k1_done", k_done, c == 8);
        end
        tick();
        chk("k1_idle_data", k_odata, 0);
        chk("k1_idle_busy", k_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
